spi_slave_sync: RTL

Parametrised SPI slave for the sequencer's host link, running entirely in the system clock domain. SCK, SS and MOSI are synchronised and edge-detected; they are never used as clocks. Supports word width, all four CPOL/CPHA modes and MSB/LSB-first order. Adds a TX holding register, an RX valid/ack handshake, and sticky overrun/underrun flags for the register-file bridge above it.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_sync.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode encoding, CPOL/CPHA helpers and
// the default filler word sent when no TX data is waiting.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  localparam logic [31:0] DEFAULT_DUMMY = 32'hFFFF_FFFF;

  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic logic lead_is_sample(input logic cpha);
    return ~cpha;
  endfunction

  function automatic logic idle_level(input logic cpol);
    return cpol;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-clk pulses
// on rising and falling transitions of the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      prev_q <= IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on the system clock: oversampled SCK/SS/MOSI,
// TX holding register, RX valid/ack handshake and sticky error flags.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CPOL        = 0,
  parameter int               CPHA        = 0,
  parameter int               LSB_FIRST   = 0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DUMMY       = WIDTH'(DEFAULT_DUMMY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_empty,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             tx_underrun,
  input  logic             flag_clr,
  output logic             busy
);

  localparam int             CW          = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST    = CW'(WIDTH - 1);
  localparam logic           IDLE_SCK    = idle_level(CPOL != 0);
  localparam logic           LEAD_SAMPLE = lead_is_sample(CPHA != 0);

  logic sck_rise, sck_fall, unused_sck_level;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(IDLE_SCK)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(sck),
    .level_o(unused_sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d_i(ss),
    .level_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi),
    .level_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             first_edge_q, first_edge_d;
  logic             reload_q, reload_d;
  logic             empty_q, empty_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ovr_q, ovr_d;
  logic             und_q, und_d;

  logic             sck_lead, sck_trail, in_frame;
  logic             sample_edge, shift_edge, skip_first;
  logic             word_done, consume;
  logic [WIDTH-1:0] rx_next, tx_word, tx_shifted;

  assign sck_lead    = (CPOL != 0) ? sck_fall : sck_rise;
  assign sck_trail   = (CPOL != 0) ? sck_rise : sck_fall;
  assign in_frame    = ~ss_s & ~ss_fall;
  assign sample_edge = in_frame & (LEAD_SAMPLE ? sck_lead : sck_trail);
  assign shift_edge  = in_frame & (LEAD_SAMPLE ? sck_trail : sck_lead);
  // With CPHA=1 the first bit is already on MISO, so the first leading edge must not shift.
  assign skip_first  = (CPHA != 0) & first_edge_q;
  assign word_done   = sample_edge & (cnt_q == CNT_LAST);
  assign consume     = ss_fall | (shift_edge & ~skip_first & reload_q);
  assign tx_word     = empty_q ? DUMMY : hold_q;

  assign rx_next    = (LSB_FIRST != 0) ? {mosi_s, rx_shift_q[WIDTH-1:1]}
                                       : {rx_shift_q[WIDTH-2:0], mosi_s};
  assign tx_shifted = (LSB_FIRST != 0) ? {1'b0, tx_shift_q[WIDTH-1:1]}
                                       : {tx_shift_q[WIDTH-2:0], 1'b0};

  always_comb begin
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    first_edge_d = first_edge_q;
    reload_d     = reload_q;

    if (ss_fall) begin
      cnt_d        = '0;
      first_edge_d = 1'b1;
      active_d     = 1'b1;
      reload_d     = 1'b0;
      tx_shift_d   = tx_word;
    end else if (ss_rise) begin
      cnt_d    = '0;
      reload_d = 1'b0;
      active_d = 1'b0;
    end else begin
      if (sample_edge) begin
        rx_shift_d = rx_next;
        if (word_done) begin
          cnt_d     = '0;
          reload_d  = 1'b1;
          rx_data_d = rx_next;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (shift_edge) begin
        first_edge_d = 1'b0;
        if (!skip_first) begin
          if (reload_q) begin
            tx_shift_d = tx_word;
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = tx_shifted;
          end
        end
      end
    end
  end

  // A load landing on the consume cycle refills the register the consume just emptied.
  always_comb begin
    hold_d  = hold_q;
    empty_d = empty_q;
    if (consume) begin
      empty_d = 1'b1;
      if (tx_load) begin
        hold_d  = tx_data;
        empty_d = 1'b0;
      end
    end else if (tx_load && empty_q) begin
      hold_d  = tx_data;
      empty_d = 1'b0;
    end
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    if (word_done) begin
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
    ovr_d = (ovr_q & ~flag_clr) | (word_done & rx_valid_q & ~rx_ack);
    und_d = (und_q & ~flag_clr) | (consume & empty_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      hold_q       <= '0;
      rx_data_q    <= '0;
      cnt_q        <= '0;
      active_q     <= 1'b0;
      first_edge_q <= 1'b0;
      reload_q     <= 1'b0;
      empty_q      <= 1'b1;
      rx_valid_q   <= 1'b0;
      ovr_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      hold_q       <= hold_d;
      rx_data_q    <= rx_data_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      first_edge_q <= first_edge_d;
      reload_q     <= reload_d;
      empty_q      <= empty_d;
      rx_valid_q   <= rx_valid_d;
      ovr_q        <= ovr_d;
      und_q        <= und_d;
    end
  end

  assign miso        = (LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[WIDTH-1];
  assign miso_oe     = active_q;
  assign busy        = active_q;
  assign tx_empty    = empty_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = ovr_q;
  assign tx_underrun = und_q;

endmodule
